// File: rtl/rotate_pkg.sv
// Shared definitions for rotate_cordic.
//   state_t   : controller states IDLE -> ROT -> [COMP] -> DONE
//   ATAN_LUT  : atan(2^-i) as a 16-bit fraction of a full turn, i = 0..15;
//               the block shifts entries right by (16-AW) to match its angle width
//   K_SH_*    : shift amounts of the gain-compensation constant
//               K = 2^-1 + 2^-3 - 2^-6 - 2^-9 (~0.6074)
package rotate_pkg;

  typedef enum logic [1:0] {IDLE, ROT, COMP, DONE} state_t;

  localparam logic [15:0] ATAN_LUT [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  // K terms: added shifts then subtracted shifts
  localparam int unsigned K_SH_A = 1;
  localparam int unsigned K_SH_B = 3;
  localparam int unsigned K_SH_C = 6;
  localparam int unsigned K_SH_D = 9;

endpackage

// File: rtl/rotate_cordic.sv
// rotate_cordic: iterative CORDIC point rotator, one micro-rotation per clock.
//   x_o = x*cos(a) + y*sin(a), y_o = y*cos(a) - x*sin(a); angle full turn = 2**AW.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   x_i, y_i, angle_i   : signed point, unsigned angle
//   out_valid/out_ready : result handshake (valid held until accepted)
//   x_o, y_o            : rounded, saturated rotated point
// Build option: define ROTATE_GAIN_COMP_EN to add the COMP state that scales the
// result by K (magnitude preserved); otherwise outputs carry the CORDIC gain ~1.6468.
module rotate_cordic
  import rotate_pkg::*;
#(
  parameter int W    = 10,
  parameter int AW   = 10,
  parameter int ITER = 10,
  parameter int G    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  input  logic [AW-1:0] angle_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  x_o,
  output logic [W-1:0]  y_o
);

  localparam int IW = W + 2 + G;
  localparam int ZW = AW + 1;
  localparam int CW = $clog2(ITER + 1);

  localparam logic signed [IW-1:0] SMAX = IW'((1 << (W - 1)) - 1);
  localparam logic signed [IW-1:0] SMIN = -SMAX - IW'(1);

  state_t                 state;
  logic signed [IW-1:0]   xr, yr;
  logic signed [ZW-1:0]   zr;
  logic [CW-1:0]          cnt;

  // pre-rotation
  logic [1:0]             q;
  logic [AW-1:0]          z_red;
  logic signed [IW-1:0]   xe, ye, px, py;
  logic signed [ZW-1:0]   z0;

  // micro-rotation
  logic [3:0]             idx;
  logic signed [ZW-1:0]   atan_z;
  logic signed [IW-1:0]   xs, ys, x_nx, y_nx;
  logic signed [ZW-1:0]   z_nx;

`ifdef ROTATE_GAIN_COMP_EN
  logic signed [IW-1:0]   kx, ky;
`endif

  function automatic logic [W-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] r;
    r = v + $signed(IW'(1 << (G - 1)));
    r = r >>> G;
    if (r > SMAX)      round_sat = SMAX[W-1:0];
    else if (r < SMIN) round_sat = SMIN[W-1:0];
    else               round_sat = r[W-1:0];
  endfunction

  always_comb begin
    // quadrant by rounding the angle to the nearest multiple of 90 deg,
    // leaving a residual in [-45,45) deg for the CORDIC run
    q     = 2'((angle_i + AW'(1 << (AW - 3))) >> (AW - 2));
    z_red = angle_i - {q, {(AW-2){1'b0}}};
    z0    = {z_red[AW-1], z_red};
    xe    = {{2{x_i[W-1]}}, x_i, {G{1'b0}}};
    ye    = {{2{y_i[W-1]}}, y_i, {G{1'b0}}};
    case (q)
      2'd0:    begin px = xe;  py = ye;  end
      2'd1:    begin px = ye;  py = -xe; end
      2'd2:    begin px = -xe; py = -ye; end
      default: begin px = -ye; py = xe;  end
    endcase

    idx    = 4'(cnt);
    atan_z = ZW'(ATAN_LUT[idx] >> (16 - AW));
    xs     = xr >>> idx;
    ys     = yr >>> idx;
    if (!zr[ZW-1]) begin
      x_nx = xr + ys;
      y_nx = yr - xs;
      z_nx = zr - atan_z;
    end else begin
      x_nx = xr - ys;
      y_nx = yr + xs;
      z_nx = zr + atan_z;
    end

`ifdef ROTATE_GAIN_COMP_EN
    kx = (xr >>> K_SH_A) + (xr >>> K_SH_B) - (xr >>> K_SH_C) - (xr >>> K_SH_D);
    ky = (yr >>> K_SH_A) + (yr >>> K_SH_B) - (yr >>> K_SH_C) - (yr >>> K_SH_D);
`endif
  end

  // ROT runs cnt = 0..ITER: the first ITER cycles are micro-rotations, the
  // closing cycle either applies K (then COMP rounds) or rounds directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_o       <= '0;
      y_o       <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr       <= px;
            yr       <= py;
            zr       <= z0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ROT;
          end
        end
        ROT: begin
          if (cnt != CW'(ITER)) begin
            xr  <= x_nx;
            yr  <= y_nx;
            zr  <= z_nx;
            cnt <= cnt + CW'(1);
          end else begin
`ifdef ROTATE_GAIN_COMP_EN
            xr    <= kx;
            yr    <= ky;
            state <= COMP;
`else
            x_o       <= round_sat(xr);
            y_o       <= round_sat(yr);
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
        COMP: begin
          x_o       <= round_sat(xr);
          y_o       <= round_sat(yr);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_cordic.sv
// Testbench for rotate_cordic (W=10, AW=10, ITER=10, G=3).
// Expected values come from ideal trigonometric rotation scaled by the CORDIC
// gain (and K when ROTATE_GAIN_COMP_EN is defined), then saturated.
module tb_rotate_cordic;

  localparam int W    = 10;
  localparam int AW   = 10;
  localparam int ITER = 10;
  localparam int G    = 3;

`ifdef ROTATE_GAIN_COMP_EN
  localparam int  LAT  = ITER + 2;
  localparam real GAIN = 1.6467602 * 0.607421875;
`else
  localparam int  LAT  = ITER + 1;
  localparam real GAIN = 1.6467602;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x_i = '0;
  logic [W-1:0]  y_i = '0;
  logic [AW-1:0] angle_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  x_o;
  logic [W-1:0]  y_o;

  int n_pass  = 0;
  int n_total = 0;

  rotate_cordic #(.W(W), .AW(AW), .ITER(ITER), .G(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .y_i       (y_i),
    .angle_i   (angle_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_o       (x_o),
    .y_o       (y_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int x, y, a;
    int ex, ey;
    int tx, ty;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_total++;
    if ((act - exp) <= tol && (exp - act) <= tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d +-%0d", name, act, exp, tol);
  endtask

  function automatic int clampi(input int v);
    if (v > 511)  return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  // Ideal rotation; tolerance widens with magnitude to cover the residual
  // angle error left by the truncated 10-bit arctangent steps.
  task automatic model(input int xi, input int yi, input int ai,
                       output int ex, output int ey, output int tol);
    real th, rx, ry, mag;
    th  = 2.0 * 3.14159265358979 * real'(ai) / 1024.0;
    rx  = GAIN * (real'(xi) * $cos(th) + real'(yi) * $sin(th));
    ry  = GAIN * (real'(yi) * $cos(th) - real'(xi) * $sin(th));
    ex  = clampi(int'(rx));
    ey  = clampi(int'(ry));
    mag = GAIN * $sqrt(real'(xi * xi + yi * yi));
    tol = 2 + int'(mag * 0.035);
  endtask

  task automatic start_job(input int xi, input int yi, input int ai);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_req", int'(in_ready), 1, 0);
    x_i      = W'(xi);
    y_i      = W'(yi);
    angle_i  = AW'(ai);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_job(output int rx, output int ry);
    rx = int'($signed(x_o));
    ry = int'($signed(y_o));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int lat, rx, ry, ex, ey, tol, hx, hy, seen;

`ifdef ROTATE_GAIN_COMP_EN
    vecs[0] = '{x:256,  y:0,   a:0,   ex:256, ey:0,    tx:2, ty:2};
    vecs[1] = '{x:256,  y:0,   a:256, ex:0,   ey:-256, tx:2, ty:2};
    vecs[2] = '{x:-300, y:100, a:512, ex:300, ey:-100, tx:2, ty:2};
    vecs[3] = '{x:400,  y:400, a:896, ex:0,   ey:511,  tx:2, ty:0};
    vecs[4] = '{x:-512, y:0,   a:512, ex:511, ey:0,    tx:0, ty:2};
`else
    vecs[0] = '{x:256,  y:0,   a:0,   ex:421, ey:0,    tx:3, ty:2};
    vecs[1] = '{x:256,  y:0,   a:256, ex:0,   ey:-421, tx:2, ty:3};
    vecs[2] = '{x:-300, y:100, a:512, ex:494, ey:-165, tx:3, ty:3};
    vecs[3] = '{x:400,  y:400, a:896, ex:0,   ey:511,  tx:3, ty:0};
    vecs[4] = '{x:-512, y:0,   a:512, ex:511, ey:0,    tx:0, ty:3};
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready",  int'(in_ready), 1, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    chk("reset_x_o", int'($signed(x_o)), 0, 0);
    chk("reset_y_o", int'($signed(y_o)), 0, 0);

    // directed vectors incl. quadrant cases and saturation
    for (int i = 0; i < 5; i++) begin
      start_job(vecs[i].x, vecs[i].y, vecs[i].a);
      chk($sformatf("vec%0d_busy", i), int'(in_ready), 0, 0);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT, 0);
      finish_job(rx, ry);
      chk($sformatf("vec%0d_x", i), rx, vecs[i].ex, vecs[i].tx);
      chk($sformatf("vec%0d_y", i), ry, vecs[i].ey, vecs[i].ty);
    end

    // random operands against the ideal model
    for (int i = 0; i < 40; i++) begin
      int xi, yi, ai;
      xi = int'($urandom_range(600)) - 300;
      yi = int'($urandom_range(600)) - 300;
      ai = int'($urandom_range(1023));
      model(xi, yi, ai, ex, ey, tol);
      start_job(xi, yi, ai);
      wait_out(lat);
      chk("rand_latency", lat, LAT, 0);
      finish_job(rx, ry);
      chk($sformatf("rand_x(%0d,%0d,%0d)", xi, yi, ai), rx, ex, tol);
      chk($sformatf("rand_y(%0d,%0d,%0d)", xi, yi, ai), ry, ey, tol);
    end

    // back-pressure in DONE: outputs hold, new requests ignored
    model(200, -150, 700, ex, ey, tol);
    start_job(200, -150, 700);
    wait_out(lat);
    chk("hold_latency", lat, LAT, 0);
    hx = int'($signed(x_o));
    hy = int'($signed(y_o));
    chk("hold_x_value", hx, ex, tol);
    chk("hold_y_value", hy, ey, tol);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1));
      x_i      = W'($urandom);
      y_i      = W'($urandom);
      angle_i  = AW'($urandom);
      @(negedge clk);
      chk("hold_x", int'($signed(x_o)), hx, 0);
      chk("hold_y", int'($signed(y_o)), hy, 0);
      chk("hold_out_valid", int'(out_valid), 1, 0);
      chk("hold_in_ready", int'(in_ready), 0, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", int'(in_ready), 1, 0);
    chk("release_out_valid", int'(out_valid), 0, 0);
    seen = 0;
    repeat (ITER + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("no_queued_job", seen, 0, 0);

    // reset in the middle of ROT drops the job
    start_job(300, 50, 300);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", int'(out_valid), 0, 0);
    chk("midreset_in_ready", int'(in_ready), 1, 0);
    chk("midreset_x_o", int'($signed(x_o)), 0, 0);
    chk("midreset_y_o", int'($signed(y_o)), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (ITER + 6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("midreset_no_emit", seen, 0, 0);

    model(-120, 330, 150, ex, ey, tol);
    start_job(-120, 330, 150);
    wait_out(lat);
    chk("after_reset_latency", lat, LAT, 0);
    finish_job(rx, ry);
    chk("after_reset_x", rx, ex, tol);
    chk("after_reset_y", ry, ey, tol);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
